// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter: FSM states,
// master count and default bus widths.
package wb_pkg;

    localparam int NUM_MASTERS    = 4;
    localparam int IDX_WIDTH      = 2;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [IDX_WIDTH-1:0] onehot_to_idx(input logic [NUM_MASTERS-1:0] oh);
        logic [IDX_WIDTH-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (oh[i]) idx = IDX_WIDTH'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin selector: scans requests starting one past the last winner
// and returns the first requester as a one-hot grant.
module rr_select
    import wb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_WIDTH-1:0]   last,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic                   valid
);

    logic [IDX_WIDTH-1:0] idx;

    // Index wraps naturally modulo 4; the final pass revisits 'last' itself.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            idx = last + IDX_WIDTH'(i);
            if (req[idx] && (gnt == '0)) gnt[idx] = 1'b1;
        end
    end

    assign valid = |req;

endmodule

// File: rtl/wb_rr_arbiter.sv
// Four-master Wishbone round-robin arbiter with bus lock on cycle.
// Optional watchdog enabled by macro WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] m0_wbm_address,
    input  logic [DATA_WIDTH-1:0] m0_wbm_writedata,
    input  logic                  m0_wbm_strobe,
    input  logic                  m0_wbm_cycle,
    input  logic                  m0_wbm_write,
    output logic [DATA_WIDTH-1:0] m0_wbm_readdata,
    output logic                  m0_wbm_ack,
    input  logic [ADDR_WIDTH-1:0] m1_wbm_address,
    input  logic [DATA_WIDTH-1:0] m1_wbm_writedata,
    input  logic                  m1_wbm_strobe,
    input  logic                  m1_wbm_cycle,
    input  logic                  m1_wbm_write,
    output logic [DATA_WIDTH-1:0] m1_wbm_readdata,
    output logic                  m1_wbm_ack,
    input  logic [ADDR_WIDTH-1:0] m2_wbm_address,
    input  logic [DATA_WIDTH-1:0] m2_wbm_writedata,
    input  logic                  m2_wbm_strobe,
    input  logic                  m2_wbm_cycle,
    input  logic                  m2_wbm_write,
    output logic [DATA_WIDTH-1:0] m2_wbm_readdata,
    output logic                  m2_wbm_ack,
    input  logic [ADDR_WIDTH-1:0] m3_wbm_address,
    input  logic [DATA_WIDTH-1:0] m3_wbm_writedata,
    input  logic                  m3_wbm_strobe,
    input  logic                  m3_wbm_cycle,
    input  logic                  m3_wbm_write,
    output logic [DATA_WIDTH-1:0] m3_wbm_readdata,
    output logic                  m3_wbm_ack,
    output logic [ADDR_WIDTH-1:0] s_wbs_address,
    output logic [DATA_WIDTH-1:0] s_wbs_writedata,
    output logic                  s_wbs_strobe,
    output logic                  s_wbs_cycle,
    output logic                  s_wbs_write,
    input  logic [DATA_WIDTH-1:0] s_wbs_readdata,
    input  logic                  s_wbs_ack,
    output logic [NUM_MASTERS-1:0] grant
);

    logic [ADDR_WIDTH-1:0]  m_addr  [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]  m_wdata [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] m_stb;
    logic [NUM_MASTERS-1:0] m_cyc;
    logic [NUM_MASTERS-1:0] m_we;
    logic [NUM_MASTERS-1:0] m_ack;

    state_t                 state;
    logic [IDX_WIDTH-1:0]   cur;
    logic [IDX_WIDTH-1:0]   last_grant;
    logic [NUM_MASTERS-1:0] sel_gnt;
    logic                   sel_valid;
    logic                   busy;
    logic                   timeout;
    logic                   release_bus;
    logic [DATA_WIDTH-1:0]  rdata;

    assign m_addr[0]  = m0_wbm_address;
    assign m_addr[1]  = m1_wbm_address;
    assign m_addr[2]  = m2_wbm_address;
    assign m_addr[3]  = m3_wbm_address;
    assign m_wdata[0] = m0_wbm_writedata;
    assign m_wdata[1] = m1_wbm_writedata;
    assign m_wdata[2] = m2_wbm_writedata;
    assign m_wdata[3] = m3_wbm_writedata;
    assign m_stb      = {m3_wbm_strobe, m2_wbm_strobe, m1_wbm_strobe, m0_wbm_strobe};
    assign m_cyc      = {m3_wbm_cycle,  m2_wbm_cycle,  m1_wbm_cycle,  m0_wbm_cycle};
    assign m_we       = {m3_wbm_write,  m2_wbm_write,  m1_wbm_write,  m0_wbm_write};

    rr_select u_rr_select (
        .req   (m_cyc),
        .last  (last_grant),
        .gnt   (sel_gnt),
        .valid (sel_valid)
    );

    assign busy        = (state == BUSY);
    assign release_bus = busy && (!m_cyc[cur] || timeout);

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_WIDTH-1:0] wd_cnt;

    // Held at zero while idle, so every new grant starts from a cleared count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (!busy || s_wbs_ack) begin
            wd_cnt <= '0;
        end else if (!timeout) begin
            wd_cnt <= wd_cnt + CNT_WIDTH'(1);
        end
    end

    assign timeout = busy && (wd_cnt == CNT_WIDTH'(TIMEOUT_CYCLES));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            cur        <= '0;
            last_grant <= '1;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        state <= BUSY;
                        grant <= sel_gnt;
                        cur   <= onehot_to_idx(sel_gnt);
                    end
                end
                BUSY: begin
                    if (release_bus) begin
                        state      <= IDLE;
                        grant      <= '0;
                        last_grant <= cur;
                    end
                end
            endcase
        end
    end

    always_comb begin
        s_wbs_address   = '0;
        s_wbs_writedata = '0;
        s_wbs_strobe    = 1'b0;
        s_wbs_cycle     = 1'b0;
        s_wbs_write     = 1'b0;
        if (busy) begin
            s_wbs_address   = m_addr[cur];
            s_wbs_writedata = m_wdata[cur];
            s_wbs_strobe    = m_stb[cur];
            s_wbs_cycle     = m_cyc[cur];
            s_wbs_write     = m_we[cur];
        end
    end

    assign m_ack = busy ? (grant & {NUM_MASTERS{s_wbs_ack | timeout}}) : '0;
    assign rdata = timeout ? '0 : s_wbs_readdata;

    assign m0_wbm_ack      = m_ack[0];
    assign m1_wbm_ack      = m_ack[1];
    assign m2_wbm_ack      = m_ack[2];
    assign m3_wbm_ack      = m_ack[3];
    assign m0_wbm_readdata = rdata;
    assign m1_wbm_readdata = rdata;
    assign m2_wbm_readdata = rdata;
    assign m3_wbm_readdata = rdata;

endmodule
